vga_draw_controller: RTL and testbench
======================================

# vga_draw_controller

Sequencer for the full-screen VGA image datapath. It accepts redraw requests from two clients: the game FSM, which supplies an arbitrary screen code, and the scoreboard logic, which always draws the fixed scoreboard code. It arbitrates between them and drives `colourmux` and `enableplotcounter` into the datapath. It also drives the `plot` strobe into the VGA adapter, issuing exactly one 160×120 sweep per granted request.

## Interface
Parameters:
- `H_PIXELS`, 160, horizontal resolution
- `V_PIXELS`, 120, vertical resolution
- `SCORE_CODE`, 6'd11, `colourmux` code used for scoreboard requests

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `game_req`  in  1  single-cycle redraw request from the game FSM
- `game_sel`  in  6  screen code for `game_req`, valid with `game_req`
- `score_req`  in  1  single-cycle scoreboard redraw request
- `colourmux`  out  6  screen select to the datapath, registered
- `enableplotcounter`  out  1  advances the datapath pixel counter
- `plot`  out  1  VGA write enable
- `busy`  out  1  high while the FSM is not in IDLE
- `done`  out  1  one-cycle pulse after the last pixel of a sweep

## Operation
- States: IDLE, LOAD, DRAW, DONE.
- Pending slots:
  - `game_pend` plus a 6-bit `game_code`.
  - `score_pend`.
  - A request on any cycle sets its slot.
  - A second `game_req` before service overwrites `game_code` with the newest value.
  - Repeated `score_req` pulses collapse into one.
- IDLE:
  - The effective request is the live request OR the pending slot.
  - Game has fixed priority over score.
  - On a grant, load `colourmux` (`game_code`/`game_sel`, or `SCORE_CODE`), clear that slot, and go to LOAD.
  - The losing request stays pending.
- LOAD: one cycle, so the ROM output settles on the new image. `enableplotcounter` = `plot` = 0. Go to DRAW.
- DRAW:
  - `enableplotcounter` = `plot` = 1.
  - A 15-bit pixel counter runs from 0 to `H_PIXELS*V_PIXELS-1` (19199).
  - At terminal count go to DONE and clear the counter.
- DONE: `done` = 1 for one cycle, then IDLE.
- `colourmux` holds its value from grant until the next grant.
- Codes above 12 are not filtered. They are drawn as-is, and the datapath default gives a black screen.
- Requests that arrive during LOAD, DRAW or DONE only set pending slots. They never abort the sweep in progress.

## Timing
- Reset values: state IDLE; `colourmux` 0 (start screen); `enableplotcounter`, `plot`, `busy`, `done` all 0; pending slots and pixel counter cleared.
- A request sampled at edge N produces:
  - LOAD during cycle N+1.
  - DRAW during cycles N+2 … N+19201.
  - `done` in cycle N+19202.
  - IDLE in cycle N+19203.
- A pending request is granted on the first IDLE cycle, so back-to-back sweeps have a one-cycle IDLE gap.
- `busy` is asserted from cycle N+1 through N+19202.
- `enableplotcounter` is high for exactly 19200 cycles per sweep. The datapath screen counter therefore returns to (0,0) without an explicit clear.
- Simultaneous `game_req` and `score_req` in IDLE: game is granted and score is left pending.
- Reset mid-DRAW: all outputs drop immediately, both pending slots are lost, and the controller returns to IDLE. The datapath counter shares `reset`, so both realign.

## Structure
- Shared package contents:
  - State encoding.
  - Screen-code constants 0–12 (START, P1TURN, P2TURN, PLAYEDBLACK, PLAYEDWHITE, P1ROUND, P2ROUND, P1WON, P2WON, SCOREBOARD, TIE, …).
  - `H_PIXELS*V_PIXELS` localparam.
- One natural sub-module is `draw_req_slot`, the pending-request latch with overwrite. It is instantiated once for game (with code) and once for score (without code).

## Test plan
- Reset, then `game_req` with `game_sel`=1 → `colourmux`=1 at N+1, `plot` high for exactly 19200 cycles, `done` at N+19202, `busy` low at N+19203.
- `game_req` (sel 7) and `score_req` in the same IDLE cycle → sweep with `colourmux`=7, then after one IDLE cycle a sweep with `colourmux`=11.
- During DRAW: `game_req` sel 3, then `game_req` sel 4 → the next sweep uses `colourmux`=4, and exactly one extra sweep occurs.
- Three `score_req` pulses during DRAW → exactly one follow-up scoreboard sweep.
- Assert `reset` at pixel 5000 → same-cycle `plot`/`busy` = 0, `colourmux`=0. A new request afterwards sweeps the full 19200 pixels.
- `game_sel`=20 → a full sweep with `colourmux`=20, and the datapath outputs colour 0 throughout.

Source files
------------

// File: rtl/vga_draw_controller_pkg.sv
// Shared state encoding, screen codes and geometry
// for the full-screen VGA draw sequencer.
package vga_draw_controller_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [5:0] SCR_START       = 6'd0;
    localparam logic [5:0] SCR_P1TURN      = 6'd1;
    localparam logic [5:0] SCR_P2TURN      = 6'd2;
    localparam logic [5:0] SCR_PLAYEDBLACK = 6'd3;
    localparam logic [5:0] SCR_PLAYEDWHITE = 6'd4;
    localparam logic [5:0] SCR_P1ROUND     = 6'd5;
    localparam logic [5:0] SCR_P2ROUND     = 6'd6;
    localparam logic [5:0] SCR_P1WON       = 6'd7;
    localparam logic [5:0] SCR_P2WON       = 6'd8;
    localparam logic [5:0] SCR_TIE         = 6'd9;
    localparam logic [5:0] SCR_ROUNDEND    = 6'd10;
    localparam logic [5:0] SCR_SCOREBOARD  = 6'd11;
    localparam logic [5:0] SCR_GAMEOVER    = 6'd12;

    localparam int H_PIX_DEF = 160;
    localparam int V_PIX_DEF = 120;
    localparam int PIXELS    = H_PIX_DEF * V_PIX_DEF;
    localparam int PIX_W     = 15;

endpackage

// File: rtl/vga_draw_controller_draw_req_slot.sv
// Pending-request latch: holds one request until granted,
// newest code wins when the slot carries a code.
module vga_draw_controller_draw_req_slot #(
    parameter int W        = 6,
    parameter bit HAS_CODE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_i,
    input  logic [W-1:0] code_i,
    input  logic         clr_i,
    output logic         eff_o,
    output logic [W-1:0] eff_code_o
);

    logic pend_q;
    logic pend_d;

    // Set on any request, cleared only when this slot is granted
    always_comb begin
        pend_d = (pend_q | req_i) & ~clr_i;
    end

    // Pending flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= 1'b0;
        else       pend_q <= pend_d;
    end

    assign eff_o = pend_q | req_i;

    if (HAS_CODE) begin : g_code
        logic [W-1:0] code_q;
        logic [W-1:0] code_d;

        // A live request overwrites the stored code
        always_comb begin
            code_d = req_i ? code_i : code_q;
        end

        // Stored code register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) code_q <= '0;
            else       code_q <= code_d;
        end

        assign eff_code_o = req_i ? code_i : code_q;
    end else begin : g_nocode
        assign eff_code_o = code_i;
    end

endmodule

// File: rtl/vga_draw_controller.sv
// Arbitrates game/scoreboard redraws and sequences one
// full-screen plot sweep per granted request.
module vga_draw_controller
    import vga_draw_controller_pkg::*;
#(
    parameter int         H_PIXELS   = H_PIX_DEF,
    parameter int         V_PIXELS   = V_PIX_DEF,
    parameter logic [5:0] SCORE_CODE = SCR_SCOREBOARD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_req,
    input  logic [5:0] game_sel,
    input  logic       score_req,
    output logic [5:0] colourmux,
    output logic       enableplotcounter,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [PIX_W-1:0] LAST_PIX =
        PIX_W'(H_PIXELS * V_PIXELS - 1);

    logic [1:0]       state_q, state_d;
    logic [5:0]       colourmux_q, colourmux_d;
    logic [PIX_W-1:0] pix_q, pix_d;

    logic       game_eff, score_eff;
    logic [5:0] game_code, score_code;
    logic       game_clr, score_clr;

    vga_draw_controller_draw_req_slot #(
        .W        (6),
        .HAS_CODE (1'b1)
    ) u_game_slot (
        .clk        (clk),
        .reset      (reset),
        .req_i      (game_req),
        .code_i     (game_sel),
        .clr_i      (game_clr),
        .eff_o      (game_eff),
        .eff_code_o (game_code)
    );

    vga_draw_controller_draw_req_slot #(
        .W        (6),
        .HAS_CODE (1'b0)
    ) u_score_slot (
        .clk        (clk),
        .reset      (reset),
        .req_i      (score_req),
        .code_i     (SCORE_CODE),
        .clr_i      (score_clr),
        .eff_o      (score_eff),
        .eff_code_o (score_code)
    );

    // Sequencer: grant in IDLE, settle, sweep, pulse done
    always_comb begin
        state_d     = state_q;
        colourmux_d = colourmux_q;
        pix_d       = pix_q;
        game_clr    = 1'b0;
        score_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (game_eff) begin
                    game_clr    = 1'b1;
                    colourmux_d = game_code;
                    state_d     = ST_LOAD;
                end else if (score_eff) begin
                    score_clr   = 1'b1;
                    colourmux_d = score_code;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_DRAW;
            ST_DRAW: begin
                if (pix_q == LAST_PIX) begin
                    pix_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, screen select and pixel counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            colourmux_q <= SCR_START;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            colourmux_q <= colourmux_d;
            pix_q       <= pix_d;
        end
    end

    assign colourmux         = colourmux_q;
    assign plot              = (state_q == ST_DRAW);
    assign enableplotcounter = (state_q == ST_DRAW);
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);

endmodule

// File: tb/tb_vga_draw_controller.sv
// Bench for vga_draw_controller: one full-size sweep plus
// directed and random scenarios on a reduced-size instance.
module tb_vga_draw_controller;

    localparam int SH    = 20;
    localparam int SV    = 12;
    localparam int P     = SH * SV;
    localparam int PF    = 160 * 120;
    localparam int SCORE = 11;

    typedef struct packed {
        logic [31:0] load;
        logic [31:0] mux;
        logic [31:0] plots;
        logic [31:0] done_c;
    } sweep_t;

    typedef struct packed {
        logic [31:0] e;
        logic        g;
        logic        s;
        logic [5:0]  sel;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, game_req, score_req;
    logic [5:0] game_sel;
    logic [5:0] mux;
    logic       en, plot, busy, done;

    logic       rst_f, greq_f, sreq_f;
    logic [5:0] gsel_f;
    logic [5:0] mux_f;
    logic       en_f, plot_f, busy_f, done_f;

    vga_draw_controller #(
        .H_PIXELS (SH),
        .V_PIXELS (SV)
    ) dut (
        .clk               (clk),
        .reset             (rst),
        .game_req          (game_req),
        .game_sel          (game_sel),
        .score_req         (score_req),
        .colourmux         (mux),
        .enableplotcounter (en),
        .plot              (plot),
        .busy              (busy),
        .done              (done)
    );

    vga_draw_controller dut_full (
        .clk               (clk),
        .reset             (rst_f),
        .game_req          (greq_f),
        .game_sel          (gsel_f),
        .score_req         (sreq_f),
        .colourmux         (mux_f),
        .enableplotcounter (en_f),
        .plot              (plot_f),
        .busy              (busy_f),
        .done              (done_f)
    );

    int checks = 0;
    int errors = 0;

    sweep_t sweeps[$];
    sweep_t expq[$];
    ev_t    evq[$];

    int     en_bad  = 0;
    int     mux_bad = 0;
    bit     in_sw   = 0;
    sweep_t cur;

    // Observe the reduced instance: one record per completed sweep
    always @(negedge clk) begin
        if (rst) begin
            in_sw = 0;
        end else begin
            if (en !== plot) en_bad++;
            if (busy && !in_sw) begin
                in_sw     = 1;
                cur.load  = cyc;
                cur.mux   = {26'd0, mux};
                cur.plots = 0;
            end
            if (in_sw) begin
                if ({26'd0, mux} !== cur.mux) mux_bad++;
                if (plot) cur.plots = cur.plots + 1;
                if (done) begin
                    cur.done_c = cyc;
                    sweeps.push_back(cur);
                    in_sw = 0;
                end
            end
        end
    end

    // Transaction-level model: requests latch into slots, a grant
    // happens on the first free edge, game beats score, and each
    // sweep occupies LOAD + P draw cycles + DONE + one IDLE cycle.
    function automatic void run_model();
        bit gp   = 0;
        bit sp   = 0;
        int gc   = 0;
        int idx  = 0;
        int free = 0;
        int g    = 0;
        expq.delete();
        for (int k = 0; k < 1000; k++) begin
            if (!gp && !sp) begin
                if (idx >= evq.size()) break;
                g = (int'(evq[idx].e) > free) ? int'(evq[idx].e) : free;
            end else begin
                g = free;
            end
            while (idx < evq.size() && int'(evq[idx].e) <= g) begin
                if (evq[idx].g) begin
                    gp = 1;
                    gc = int'(evq[idx].sel);
                end
                if (evq[idx].s) sp = 1;
                idx++;
            end
            expq.push_back('{load: g, mux: (gp ? gc : SCORE),
                             plots: P, done_c: g + P + 1});
            if (gp) gp = 0;
            else    sp = 0;
            free = g + P + 3;
        end
    endfunction

    task automatic pulse(input bit g, input bit s, input logic [5:0] sel);
        game_req  = g;
        score_req = s;
        game_sel  = sel;
        evq.push_back('{e: cyc + 1, g: g, s: s, sel: sel});
        @(negedge clk);
        game_req  = 1'b0;
        score_req = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int idle = 0;
        int n    = 0;
        while (idle < 3 && n < 20000) begin
            @(negedge clk);
            n++;
            if (!busy) idle++;
            else       idle = 0;
        end
        checks++;
        if (idle < 3) begin
            errors++;
            $display("FAIL %s timeout: busy=%0b after %0d cycles, want idle",
                     name, busy, n);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({mux, en, plot, busy, done} !== 10'd0) begin
            errors++;
            $display("FAIL reset_small got %b want 0", {mux, en, plot, busy, done});
        end
        checks++;
        if ({mux_f, en_f, plot_f, busy_f, done_f} !== 10'd0) begin
            errors++;
            $display("FAIL reset_full got %b want 0",
                     {mux_f, en_f, plot_f, busy_f, done_f});
        end
        rst   = 1'b0;
        rst_f = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mux, busy, plot} !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle got %b want 0", {mux, busy, plot});
        end
    endtask

    task automatic test_full_sweep();
        int n0;
        int plots   = 0;
        int ens     = 0;
        int dones   = 0;
        int done_at = -1;
        int idle_at = -1;
        greq_f = 1'b1;
        gsel_f = 6'd1;
        n0     = cyc + 1;
        @(negedge clk);
        greq_f = 1'b0;
        checks++;
        if ({mux_f, busy_f, plot_f, en_f} !== {6'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_load got mux=%0d busy=%0b plot=%0b want mux=1 busy=1 plot=0",
                     mux_f, busy_f, plot_f);
        end
        for (int k = 0; k < 19400 && idle_at < 0; k++) begin
            if (plot_f) plots++;
            if (en_f)   ens++;
            if (done_f) begin
                dones++;
                if (done_at < 0) done_at = cyc;
            end
            if (!busy_f) idle_at = cyc;
            @(negedge clk);
        end
        checks++;
        if (plots != PF) begin
            errors++;
            $display("FAIL full_plots got %0d want %0d", plots, PF);
        end
        checks++;
        if (ens != PF) begin
            errors++;
            $display("FAIL full_enable got %0d want %0d", ens, PF);
        end
        checks++;
        if (dones != 1 || done_at != n0 + PF + 1) begin
            errors++;
            $display("FAIL full_done got n=%0d at=%0d want n=1 at=%0d",
                     dones, done_at, n0 + PF + 1);
        end
        checks++;
        if (idle_at != n0 + PF + 2) begin
            errors++;
            $display("FAIL full_idle got %0d want %0d", idle_at, n0 + PF + 2);
        end
    endtask

    task automatic test_priority();
        evq.delete();
        sweeps.delete();
        pulse(1'b1, 1'b1, 6'd7);
        wait_quiet("priority");
        run_model();
        checks++;
        if (sweeps.size() != 2 || expq.size() != 2) begin
            errors++;
            $display("FAIL priority count got %0d want 2 (model %0d)",
                     sweeps.size(), expq.size());
        end
        foreach (expq[i]) if (i < sweeps.size()) begin
            checks++;
            if (sweeps[i] !== expq[i]) begin
                errors++;
                $display("FAIL priority sweep%0d got mux=%0d load=%0d plots=%0d done=%0d want mux=%0d load=%0d plots=%0d done=%0d",
                         i, sweeps[i].mux, sweeps[i].load, sweeps[i].plots, sweeps[i].done_c,
                         expq[i].mux, expq[i].load, expq[i].plots, expq[i].done_c);
            end
        end
    endtask

    task automatic test_overwrite();
        evq.delete();
        sweeps.delete();
        pulse(1'b1, 1'b0, 6'd2);
        repeat (30) @(negedge clk);
        pulse(1'b1, 1'b0, 6'd3);
        repeat (40) @(negedge clk);
        pulse(1'b1, 1'b0, 6'd4);
        wait_quiet("overwrite");
        run_model();
        checks++;
        if (sweeps.size() != 2 || sweeps.size() > 1 && sweeps[1].mux != 4) begin
            errors++;
            $display("FAIL overwrite count=%0d want 2 with second mux=4", sweeps.size());
        end
        foreach (expq[i]) if (i < sweeps.size()) begin
            checks++;
            if (sweeps[i] !== expq[i]) begin
                errors++;
                $display("FAIL overwrite sweep%0d got mux=%0d load=%0d plots=%0d done=%0d want mux=%0d load=%0d plots=%0d done=%0d",
                         i, sweeps[i].mux, sweeps[i].load, sweeps[i].plots, sweeps[i].done_c,
                         expq[i].mux, expq[i].load, expq[i].plots, expq[i].done_c);
            end
        end
    endtask

    task automatic test_score_collapse();
        evq.delete();
        sweeps.delete();
        pulse(1'b1, 1'b0, 6'd6);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 6'd0);
            repeat (10) @(negedge clk);
        end
        wait_quiet("collapse");
        run_model();
        checks++;
        if (sweeps.size() != 2 || expq.size() != 2) begin
            errors++;
            $display("FAIL collapse count got %0d want 2", sweeps.size());
        end
        foreach (expq[i]) if (i < sweeps.size()) begin
            checks++;
            if (sweeps[i] !== expq[i]) begin
                errors++;
                $display("FAIL collapse sweep%0d got mux=%0d load=%0d plots=%0d done=%0d want mux=%0d load=%0d plots=%0d done=%0d",
                         i, sweeps[i].mux, sweeps[i].load, sweeps[i].plots, sweeps[i].done_c,
                         expq[i].mux, expq[i].load, expq[i].plots, expq[i].done_c);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        evq.delete();
        sweeps.delete();
        pulse(1'b1, 1'b0, 6'd5);
        repeat (100) @(negedge clk);
        pulse(1'b1, 1'b1, 6'd8);
        repeat (5) @(negedge clk);
        checks++;
        if (plot !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre plot got %0b want 1", plot);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mux, en, plot, busy, done} !== 10'd0) begin
            errors++;
            $display("FAIL midreset_drop got %b want 0", {mux, en, plot, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        evq.delete();
        sweeps.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pending busy got %0b want 0", busy);
        end
        pulse(1'b1, 1'b0, 6'd9);
        wait_quiet("midreset");
        run_model();
        checks++;
        if (sweeps.size() != 1) begin
            errors++;
            $display("FAIL midreset count got %0d want 1", sweeps.size());
        end
        foreach (expq[i]) if (i < sweeps.size()) begin
            checks++;
            if (sweeps[i] !== expq[i]) begin
                errors++;
                $display("FAIL midreset sweep%0d got mux=%0d load=%0d plots=%0d done=%0d want mux=%0d load=%0d plots=%0d done=%0d",
                         i, sweeps[i].mux, sweeps[i].load, sweeps[i].plots, sweeps[i].done_c,
                         expq[i].mux, expq[i].load, expq[i].plots, expq[i].done_c);
            end
        end
    endtask

    task automatic test_out_of_range();
        evq.delete();
        sweeps.delete();
        pulse(1'b1, 1'b0, 6'd20);
        wait_quiet("oor");
        run_model();
        checks++;
        if (sweeps.size() != 1) begin
            errors++;
            $display("FAIL oor count got %0d want 1", sweeps.size());
        end
        foreach (expq[i]) if (i < sweeps.size()) begin
            checks++;
            if (sweeps[i] !== expq[i]) begin
                errors++;
                $display("FAIL oor sweep%0d got mux=%0d plots=%0d want mux=%0d plots=%0d",
                         i, sweeps[i].mux, sweeps[i].plots, expq[i].mux, expq[i].plots);
            end
        end
        checks++;
        if (mux !== 6'd20) begin
            errors++;
            $display("FAIL oor hold got %0d want 20", mux);
        end
    endtask

    task automatic test_random();
        evq.delete();
        sweeps.delete();
        for (int i = 0; i < 40; i++) begin
            int gap  = int'($urandom_range(0, P + 20));
            int kind = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            pulse(kind != 1, kind != 0, 6'($urandom_range(0, 63)));
        end
        wait_quiet("random");
        run_model();
        checks++;
        if (sweeps.size() != expq.size()) begin
            errors++;
            $display("FAIL random count got %0d want %0d", sweeps.size(), expq.size());
        end
        foreach (expq[i]) if (i < sweeps.size()) begin
            checks++;
            if (sweeps[i] !== expq[i]) begin
                errors++;
                $display("FAIL random sweep%0d got mux=%0d load=%0d plots=%0d done=%0d want mux=%0d load=%0d plots=%0d done=%0d",
                         i, sweeps[i].mux, sweeps[i].load, sweeps[i].plots, sweeps[i].done_c,
                         expq[i].mux, expq[i].load, expq[i].plots, expq[i].done_c);
            end
        end
    endtask

    task automatic test_integrity();
        checks++;
        if (en_bad != 0) begin
            errors++;
            $display("FAIL enable_vs_plot got %0d differing cycles want 0", en_bad);
        end
        checks++;
        if (mux_bad != 0) begin
            errors++;
            $display("FAIL mux_hold got %0d changes mid-sweep want 0", mux_bad);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rst_f     = 1'b1;
        game_req  = 1'b0;
        score_req = 1'b0;
        game_sel  = 6'd0;
        greq_f    = 1'b0;
        sreq_f    = 1'b0;
        gsel_f    = 6'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_full_sweep();
        test_priority();
        test_overwrite();
        test_score_collapse();
        test_reset_mid_draw();
        test_out_of_range();
        test_random();
        test_integrity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
